// File: rtl/attopu_fetch_pkg.sv
// Shared attopu fetch defaults: address/instruction widths, reset PC, FIFO entry width.
package attopu_fetch_pkg;
  localparam int unsigned ATTOPU_ADDR_W   = 16;
  localparam int unsigned ATTOPU_INSTR_W  = 16;
  localparam logic [15:0] ATTOPU_RESET_PC = 16'h0000;
  localparam int unsigned ATTOPU_ENTRY_W  = ATTOPU_ADDR_W + ATTOPU_INSTR_W;
endpackage

// File: rtl/attopu_fetch_if.sv
// Fetch-stage bus: instruction memory port plus core-side valid/ready and redirect.
interface attopu_fetch_if
  import attopu_fetch_pkg::*;
#(
  parameter int unsigned ADDR_W  = ATTOPU_ADDR_W,
  parameter int unsigned INSTR_W = ATTOPU_INSTR_W
);
  logic               imem_req;
  logic [ADDR_W-1:0]  imem_addr;
  logic [INSTR_W-1:0] imem_rdata;
  logic               redirect;
  logic [ADDR_W-1:0]  redirect_pc;
  logic               instr_valid;
  logic [INSTR_W-1:0] instr;
  logic [ADDR_W-1:0]  instr_pc;
  logic               instr_ready;
  logic [ADDR_W-1:0]  fetch_pc;

  modport master (
    output imem_req, imem_addr, instr_valid, instr, instr_pc, fetch_pc,
    input  imem_rdata, redirect, redirect_pc, instr_ready
  );

  modport slave (
    input  imem_req, imem_addr, instr_valid, instr, instr_pc, fetch_pc,
    output imem_rdata, redirect, redirect_pc, instr_ready
  );
endinterface

// File: rtl/attopu_fetch_fifo.sv
// attopu_fifo: DEPTH x W synchronous FIFO with push/pop/flush and occupancy flags.
module attopu_fifo #(
  parameter int unsigned W     = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_push,
  input  logic                       i_pop,
  input  logic                       i_flush,
  input  logic [W-1:0]               i_wdata,
  output logic [W-1:0]               o_rdata,
  output logic [$clog2(DEPTH):0]     o_count,
  output logic                       o_empty,
  output logic                       o_full
);
  localparam int unsigned PW = $clog2(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [PW-1:0] r_wp;
  logic [PW-1:0] r_rp;
  logic [PW:0]   r_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else if (i_flush) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (i_push) r_wp <= r_wp + 1'b1;
      if (i_pop)  r_rp <= r_rp + 1'b1;
      case ({i_push, i_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (i_push && !i_flush) r_mem[r_wp] <= i_wdata;
  end

  assign o_rdata = r_mem[r_rp];
  assign o_count = r_cnt;
  assign o_empty = (r_cnt == '0);
  assign o_full  = (r_cnt == (PW+1)'(DEPTH));
endmodule

// File: rtl/attopu_fetch.sv
// attopu fetch stage: sequential imem fetch, prefetch FIFO, valid/ready to core, redirect flush.
// Optional ATTOPU_FETCH_BYPASS_EN: a live response into an empty FIFO is presented the same cycle.
module attopu_fetch
  import attopu_fetch_pkg::*;
#(
  parameter int unsigned       ADDR_W   = ATTOPU_ADDR_W,
  parameter int unsigned       INSTR_W  = ATTOPU_INSTR_W,
  parameter int unsigned       DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(ATTOPU_RESET_PC)
) (
  input  logic           clk,
  input  logic           rst,
  attopu_fetch_if.master bus
);
  localparam int unsigned ENTRY_W = ADDR_W + INSTR_W;
  localparam int unsigned CNT_W   = $clog2(DEPTH) + 1;

  logic [ADDR_W-1:0]  r_fetch_pc;
  logic               r_inflight;
  logic [ADDR_W-1:0]  r_inflight_pc;
  logic               r_kill;

  logic [ENTRY_W-1:0] w_head;
  logic [CNT_W-1:0]   w_count;
  logic               w_empty;
  logic               w_full;
  logic               w_credit;
  logic               w_req;
  logic               w_live;
  logic               w_byp;
  logic               w_push;
  logic               w_pop;

  // count + inflight < DEPTH, expressed via the FIFO flags
  assign w_credit = !w_full && !(r_inflight && (w_count == CNT_W'(DEPTH - 1)));
  assign w_req    = rst && w_credit && !bus.redirect;
  assign w_live   = r_inflight && !r_kill && !bus.redirect;

`ifdef ATTOPU_FETCH_BYPASS_EN
  assign w_byp = w_empty && w_live;
`else
  assign w_byp = 1'b0;
`endif

  assign w_push = w_live && !(w_byp && bus.instr_ready);
  assign w_pop  = !w_empty && bus.instr_ready;

  attopu_fifo #(
    .W     (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (bus.redirect),
    .i_wdata ({r_inflight_pc, bus.imem_rdata}),
    .o_rdata (w_head),
    .o_count (w_count),
    .o_empty (w_empty),
    .o_full  (w_full)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_fetch_pc    <= RESET_PC;
      r_inflight    <= 1'b0;
      r_inflight_pc <= '0;
      r_kill        <= 1'b0;
    end else begin
      r_kill     <= bus.redirect;
      r_inflight <= w_req;
      if (bus.redirect) begin
        r_fetch_pc <= bus.redirect_pc;
      end else if (w_req) begin
        r_fetch_pc    <= r_fetch_pc + 1'b1;
        r_inflight_pc <= r_fetch_pc;
      end
    end
  end

  always_comb begin
    bus.instr_valid = 1'b0;
    bus.instr       = '0;
    bus.instr_pc    = '0;
    if (!w_empty) begin
      bus.instr_valid = 1'b1;
      {bus.instr_pc, bus.instr} = w_head;
    end else if (w_byp) begin
      bus.instr_valid = 1'b1;
      bus.instr_pc    = r_inflight_pc;
      bus.instr       = bus.imem_rdata;
    end
  end

  assign bus.imem_req  = w_req;
  assign bus.imem_addr = r_fetch_pc;
  assign bus.fetch_pc  = r_fetch_pc;
endmodule

// File: tb/tb_attopu_fetch.sv
// Bench for attopu_fetch: randomized handshake/redirect stimulus against an occupancy/PC-sequence model.
module tb_attopu_fetch;
  import attopu_fetch_pkg::*;

  localparam int unsigned DEPTH = 4;
  localparam logic [15:0] RST_PC = 16'h0000;
`ifdef ATTOPU_FETCH_BYPASS_EN
  localparam int LAT = 1;
  localparam bit BYP = 1'b1;
`else
  localparam int LAT = 2;
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  attopu_fetch_if #(.ADDR_W(16), .INSTR_W(16)) bus ();

  attopu_fetch #(
    .ADDR_W   (16),
    .INSTR_W  (16),
    .DEPTH    (DEPTH),
    .RESET_PC (RST_PC)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int unsigned total = 0;
  int unsigned bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // drive values applied on the next step
  logic        d_rst   = 1'b0;
  logic        d_ready = 1'b1;
  logic        d_redir = 1'b0;
  logic [15:0] d_rpc   = 16'h0000;

  // reference state: issued-but-undelivered count, next expected PCs, memory pipe
  int          outs      = 0;
  logic        prev_req  = 1'b0;
  logic [15:0] exp_pc    = RST_PC;
  logic [15:0] exp_fetch = RST_PC;
  logic        pend      = 1'b0;
  logic [15:0] pend_addr = 16'h0000;
  int          cyc       = 0;
  int          first_req = -1;
  logic        lat_armed = 1'b0;

  function automatic logic [15:0] word(input logic [15:0] a);
    return 16'h1000 + a;
  endfunction

  task automatic sample();
    logic exp_req, exp_valid, xfer;
    int   buffered;
    if (!rst) begin
      check("rst_req", {31'd0, bus.imem_req}, 32'd0);
      check("rst_valid", {31'd0, bus.instr_valid}, 32'd0);
      check("rst_fetch_pc", {16'd0, bus.fetch_pc}, {16'd0, RST_PC});
      outs = 0; prev_req = 1'b0; exp_pc = RST_PC; exp_fetch = RST_PC;
      pend = 1'b0; first_req = -1; lat_armed = 1'b1;
      return;
    end
    exp_req  = (outs < DEPTH) && !d_redir;
    buffered = outs - (prev_req ? 1 : 0);
    exp_valid = (buffered > 0) || (BYP && prev_req && !d_redir);
    check("req", {31'd0, bus.imem_req}, {31'd0, exp_req});
    check("fetch_pc", {16'd0, bus.fetch_pc}, {16'd0, exp_fetch});
    if (bus.imem_req) check("addr", {16'd0, bus.imem_addr}, {16'd0, exp_fetch});
    check("valid", {31'd0, bus.instr_valid}, {31'd0, exp_valid});
    if (bus.instr_valid) begin
      check("pc", {16'd0, bus.instr_pc}, {16'd0, exp_pc});
      check("instr", {16'd0, bus.instr}, {16'd0, word(exp_pc)});
    end else begin
      check("idle_zero", {bus.instr_pc, bus.instr}, 32'd0);
    end
    if (lat_armed) begin
      if (bus.imem_req && first_req < 0) first_req = cyc;
      if (bus.instr_valid) begin
        check("latency", cyc - first_req, LAT);
        lat_armed = 1'b0;
      end
    end
    xfer = bus.instr_valid && d_ready;
    if (xfer) exp_pc = exp_pc + 16'd1;
    if (d_redir) begin
      outs = 0;
      exp_pc = d_rpc;
      exp_fetch = d_rpc;
    end else begin
      outs = outs + (bus.imem_req ? 1 : 0) - (xfer ? 1 : 0);
      if (bus.imem_req) exp_fetch = exp_fetch + 16'd1;
    end
    prev_req  = bus.imem_req;
    pend      = bus.imem_req;
    pend_addr = bus.imem_addr;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    rst             = d_rst;
    bus.instr_ready = d_ready;
    bus.redirect    = d_redir;
    bus.redirect_pc = d_rpc;
    bus.imem_rdata  = pend ? word(pend_addr) : 16'($urandom);
    if (!d_rst) begin
      #1;
      check("rst_now_valid", {31'd0, bus.instr_valid}, 32'd0);
      check("rst_now_out", {bus.instr_pc, bus.instr}, 32'd0);
      check("rst_now_req", {31'd0, bus.imem_req}, 32'd0);
    end
    @(negedge clk);
    cyc++;
    sample();
  endtask

  initial begin
    bit found;
    bus.instr_ready = 1'b1;
    bus.redirect    = 1'b0;
    bus.redirect_pc = '0;
    bus.imem_rdata  = '0;
    d_rst = 1'b0;
    repeat (2) step();

    // streaming after reset, ready always high
    d_rst = 1'b1; d_ready = 1'b1;
    repeat (20) step();

    // core stalls: FIFO fills to DEPTH and fetch stops
    d_ready = 1'b0;
    repeat (10) step();
    check("stall_req", {31'd0, bus.imem_req}, 32'd0);
    check("stall_held", outs, DEPTH);
    d_ready = 1'b1;
    repeat (10) step();

    // redirect while 3 buffered and one response in flight
    d_ready = 1'b0; d_redir = 1'b1; d_rpc = 16'h0000;
    step();
    d_redir = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (outs == DEPTH && prev_req) begin
        found = 1'b1;
        break;
      end
      step();
    end
    check("t3_setup", {31'd0, found}, 32'd1);
    d_redir = 1'b1; d_rpc = 16'h0040;
    step();
    d_redir = 1'b0; d_ready = 1'b1;
    repeat (10) step();

    // address wrap
    d_redir = 1'b1; d_rpc = 16'hfffe;
    step();
    d_redir = 1'b0;
    repeat (8) step();
    check("wrap_pc", {16'd0, exp_pc[15:8]}, 32'd0);

    // reset mid-stream with a request in flight
    repeat (5) step();
    d_rst = 1'b0;
    repeat (2) step();
    d_rst = 1'b1;
    repeat (10) step();

    // randomized traffic with redirects, including back-to-back and near-wrap
    for (int i = 0; i < 400; i++) begin
      d_ready = ($urandom_range(0, 3) != 0);
      d_redir = ($urandom_range(0, 15) == 0);
      d_rpc   = $urandom_range(0, 1) ? (16'hfff0 + 16'($urandom_range(0, 15))) : 16'($urandom);
      step();
    end
    d_redir = 1'b0; d_ready = 1'b1;
    repeat (10) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
